// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter. Accepts one DATA_BITS-wide word over a valid/ready
// handshake and sends it LSB-first on tx_out as a frame of one start bit
// (space), DATA_BITS data bits and STOP_BITS stop bits (mark). Every bit
// lasts exactly BAUD_DIV clock cycles. The line idles at mark.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   tx_en      transmitter enable, gates acceptance of new frames only
//   valid_in   tx_data is valid (producer side of the handshake)
//   tx_data    word to send, sampled on the accept edge
//   ready_out  block can accept a frame this cycle
//   tx_out     registered serial line
//   busy       a frame is in progress (any state other than IDLE)
//   tx_done    one-cycle pulse on the last cycle of the final stop bit
module uart_tx #(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_en,
   input  logic                 valid_in,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 ready_out,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BAUD_W-1:0]    baud_cnt_next;
   logic [BIT_W-1:0]     bit_cnt;
   logic [BIT_W-1:0]     bit_cnt_next;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_next;
   logic                 tx_out_next;
   logic                 bit_tick;
   logic                 accept;

   // A bit period ends when the baud counter reaches its last value; the
   // counter is held at zero while idle so this never fires in IDLE.
   assign bit_tick = (state != IDLE) && (baud_cnt == BAUD_LAST);
   assign accept   = valid_in && ready_out;

   // State register together with the datapath registers. tx_out is
   // registered from the value the line must carry in the next state, so
   // the start bit appears on the line in the cycle right after accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx_out   <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_cnt_next;
         bit_cnt  <= bit_cnt_next;
         shift    <= shift_next;
         tx_out   <= tx_out_next;
      end
   end

   // Next-state logic. The bit counter is reused: it counts data bits in
   // DATA and stop bits in STOP, and is cleared on entry to each.
   always_comb begin
      state_next    = state;
      baud_cnt_next = baud_cnt;
      bit_cnt_next  = bit_cnt;
      shift_next    = shift;

      if (state != IDLE) begin
         baud_cnt_next = bit_tick ? '0 : baud_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               state_next    = START;
               shift_next    = tx_data;
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
            end
         end
         START: begin
            if (bit_tick) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_next = shift >> 1;
               if (bit_cnt == DATA_LAST) begin
                  state_next   = STOP;
                  bit_cnt_next = '0;
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (bit_cnt == STOP_LAST) begin
                  state_next   = IDLE;
                  bit_cnt_next = '0;
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      case (state_next)
         START:   tx_out_next = 1'b0;
         DATA:    tx_out_next = shift_next[0];
         default: tx_out_next = 1'b1;
      endcase
   end

   // Handshake and status outputs. ready_out is qualified with reset_n so
   // it drops immediately when reset is asserted, even though the state
   // register already reads IDLE at that point.
   always_comb begin
      ready_out = reset_n && tx_en && (state == IDLE);
      busy      = (state != IDLE);
      tx_done   = (state == STOP) && bit_tick && (bit_cnt == STOP_LAST);
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Testbench for uart_tx. Three instances with different frame formats
// share one clock, reset and tx_en; a selector routes one of them to a
// frame monitor. Words are pushed to an expected-data queue at the accept
// edge and popped when the monitor has decoded a complete frame from the
// line, checking bit timing, tx_done, busy and the idle cycle after it.
module tb_uart_tx;

   logic       clk;
   logic       reset_n;
   logic       tx_en;
   logic       valid_req;
   logic [7:0] tx_data;
   int         sel;

   logic valid0, ready0, tx0, busy0, done0;
   logic valid1, ready1, tx1, busy1, done1;
   logic valid2, ready2, tx2, busy2, done2;
   logic tx_m, ready_m, busy_m, done_m;

   int baud_cfg [3] = '{4, 3, 4};
   int bits_cfg [3] = '{8, 8, 5};
   int stop_cfg [3] = '{1, 2, 1};

   int         compare_count  = 0;
   int         mismatch_count = 0;
   int         cycle_count    = 0;
   int         frames_done    = 0;
   logic [7:0] exp_q [$];

   assign valid0 = valid_req && (sel == 0);
   assign valid1 = valid_req && (sel == 1);
   assign valid2 = valid_req && (sel == 2);

   uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .valid_in(valid0),
      .tx_data(tx_data), .ready_out(ready0), .tx_out(tx0), .busy(busy0),
      .tx_done(done0)
   );

   uart_tx #(.BAUD_DIV(3), .DATA_BITS(8), .STOP_BITS(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .valid_in(valid1),
      .tx_data(tx_data), .ready_out(ready1), .tx_out(tx1), .busy(busy1),
      .tx_done(done1)
   );

   uart_tx #(.BAUD_DIV(4), .DATA_BITS(5), .STOP_BITS(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .valid_in(valid2),
      .tx_data(tx_data[4:0]), .ready_out(ready2), .tx_out(tx2), .busy(busy2),
      .tx_done(done2)
   );

   // Free-running clock and a posedge counter used to time accept edges.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle_count++;

   // Route the selected instance to the monitor.
   always_comb begin
      case (sel)
         1: begin
            tx_m = tx1; ready_m = ready1; busy_m = busy1; done_m = done1;
         end
         2: begin
            tx_m = tx2; ready_m = ready2; busy_m = busy2; done_m = done2;
         end
         default: begin
            tx_m = tx0; ready_m = ready0; busy_m = busy0; done_m = done0;
         end
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drive one word to instance `which`, waiting (bounded) for ready_out.
   // The expected word, truncated to that instance's width, is queued at
   // the accept edge. With hold set, valid stays high afterwards.
   task automatic applyStimulus(input int which, input logic [7:0] data,
                                input bit hold, output int accept_at);
      int         wait_cycles = 0;
      logic [7:0] mask;
      mask      = 8'((1 << bits_cfg[which]) - 1);
      accept_at = -1;
      sel       = which;
      @(negedge clk);
      tx_data   = data;
      valid_req = 1'b1;
      while (!ready_m && wait_cycles < 300) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (!ready_m) begin
         checkOutput("acceptTimeout", 32'(ready_m), 32'd1);
         valid_req = 1'b0;
         return;
      end
      exp_q.push_back(data & mask);
      accept_at = cycle_count;
      @(posedge clk);
      #1;
      if (!hold) valid_req = 1'b0;
   endtask

   task automatic waitFrames(input int target);
      int t = 0;
      while (frames_done < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("frameCount", 32'(frames_done), 32'(target));
      repeat (2) @(negedge clk);
   endtask

   // Frame monitor. Sampled on the falling edge. A frame starts at the
   // first low sample; each bit must hold its first-sampled level for the
   // whole bit period, start must be low and stop bits high. tx_done must
   // be high only on the last frame cycle and busy throughout. The cycle
   // after the frame must be idle mark with ready_out following tx_en.
   bit         mon_active = 1'b0;
   bit         mon_post   = 1'b0;
   int         mon_cycle, mon_len, mon_baud, mon_bits, bit_idx;
   int         glitches, done_errs, busy_errs;
   logic       bit_val;
   logic [7:0] cap_data;
   logic [7:0] exp_data;

   always @(negedge clk) begin
      if (!reset_n) begin
         mon_active = 1'b0;
         mon_post   = 1'b0;
      end else begin
         if (mon_post) begin
            mon_post = 1'b0;
            checkOutput("idleLine", 32'(tx_m), 32'd1);
            checkOutput("busyIdle", 32'(busy_m), 32'd0);
            checkOutput("doneIdle", 32'(done_m), 32'd0);
            checkOutput("readyIdle", 32'(ready_m), 32'(tx_en));
         end else if (!mon_active && tx_m == 1'b0) begin
            mon_active = 1'b1;
            mon_cycle  = 0;
            mon_baud   = baud_cfg[sel];
            mon_bits   = bits_cfg[sel];
            mon_len    = mon_baud * (1 + mon_bits + stop_cfg[sel]);
            glitches   = 0;
            done_errs  = 0;
            busy_errs  = 0;
            cap_data   = '0;
         end
         if (mon_active) begin
            bit_idx = mon_cycle / mon_baud;
            if (mon_cycle % mon_baud == 0) bit_val = tx_m;
            else if (tx_m !== bit_val) glitches++;
            if (bit_idx == 0) begin
               if (tx_m !== 1'b0) glitches++;
            end else if (bit_idx <= mon_bits) begin
               cap_data[bit_idx-1] = bit_val;
            end else if (tx_m !== 1'b1) begin
               glitches++;
            end
            if (done_m !== (mon_cycle == mon_len - 1)) done_errs++;
            if (busy_m !== 1'b1) busy_errs++;
            mon_cycle++;
            if (mon_cycle == mon_len) begin
               checkOutput("frameExpected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  exp_data = exp_q.pop_front();
                  checkOutput("frameData", 32'(cap_data), 32'(exp_data));
               end
               checkOutput("bitTiming", 32'(glitches), 32'd0);
               checkOutput("doneTiming", 32'(done_errs), 32'd0);
               checkOutput("busyFrame", 32'(busy_errs), 32'd0);
               mon_active = 1'b0;
               mon_post   = 1'b1;
               frames_done++;
            end
         end
      end
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a1, a2, errs;
      reset_n   = 1'b0;
      tx_en     = 1'b0;
      valid_req = 1'b0;
      tx_data   = '0;
      sel       = 0;

      // Reset state.
      #12;
      checkOutput("rstTx", 32'(tx0), 32'd1);
      checkOutput("rstBusy", 32'(busy0), 32'd0);
      checkOutput("rstReady", 32'(ready0), 32'd0);
      checkOutput("rstDone", 32'(done0), 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      tx_en   = 1'b1;

      // Single 0xA5 frame, 40 cycles.
      applyStimulus(0, 8'hA5, 1'b0, a1);
      waitFrames(1);

      // Back-to-back with valid held; data changed during frame one.
      applyStimulus(0, 8'h00, 1'b1, a1);
      applyStimulus(0, 8'hFF, 1'b0, a2);
      checkOutput("b2bGap", 32'(a2 - a1), 32'd41);
      waitFrames(3);

      // Asynchronous reset at cycle 15 of a frame.
      applyStimulus(0, 8'h5A, 1'b0, a1);
      repeat (14) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midRstTx", 32'(tx0), 32'd1);
      checkOutput("midRstBusy", 32'(busy0), 32'd0);
      checkOutput("midRstReady", 32'(ready0), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("readyAfterRst", 32'(ready0), 32'd1);
      applyStimulus(0, 8'hC3, 1'b0, a1);
      waitFrames(4);

      // tx_en low while valid is offered: nothing happens.
      tx_en = 1'b0;
      @(negedge clk);
      sel       = 0;
      valid_req = 1'b1;
      errs      = 0;
      repeat (20) begin
         @(negedge clk);
         if (ready0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) errs++;
      end
      checkOutput("enOffIdle", 32'(errs), 32'd0);
      valid_req = 1'b0;
      tx_en     = 1'b1;

      // tx_en dropped at cycle 10 of a frame: frame completes, no re-accept.
      applyStimulus(0, 8'h3C, 1'b1, a1);
      repeat (9) @(posedge clk);
      #2;
      tx_en = 1'b0;
      waitFrames(5);
      errs = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy0 !== 1'b0 || tx0 !== 1'b1 || ready0 !== 1'b0) errs++;
      end
      checkOutput("noAcceptEnOff", 32'(errs), 32'd0);
      valid_req = 1'b0;
      tx_en     = 1'b1;

      // Two stop bits, BAUD_DIV=3: 33-cycle frame.
      applyStimulus(1, 8'h3C, 1'b0, a1);
      waitFrames(6);

      // Five data bits: upper tx_data bits are not sent, 28-cycle frame.
      applyStimulus(2, 8'hFF, 1'b0, a1);
      waitFrames(7);

      checkOutput("queueDrained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compare_count, mismatch_count);
      $finish;
   end

endmodule
